// File: rtl/srsystem_frame_counter_if.sv
// rtl/srsystem_frame_counter_if.sv - control/status bundle between bit timing, frame counter and frame consumer
interface srsystem_frame_counter_if #(
    parameter int CW  = 4,
    parameter int FCW = 8
);
    logic           start;
    logic           abort;
    logic           bit_en;
    logic [CW-1:0]  frame_len;
    logic           RXF;
    logic           busy;
    logic [CW-1:0]  bit_idx;
    logic [FCW-1:0] frame_cnt;
    logic           overrun;
    logic           len_err;

    modport master (
        output start, abort, bit_en, frame_len,
        input  RXF, busy, bit_idx, frame_cnt, overrun, len_err
    );

    modport slave (
        input  start, abort, bit_en, frame_len,
        output RXF, busy, bit_idx, frame_cnt, overrun, len_err
    );
endinterface

// File: rtl/srsystem_frame_counter.sv
// rtl/srsystem_frame_counter.sv - receive bit/frame counter with start/abort, frame tally and error flags
module srsystem_frame_counter #(
    parameter int MAX_BITS  = 11,
    parameter int CW        = 4,
    parameter int FCW       = 8,
    parameter bit HOLD_MODE = 1'b1
) (
    input  logic                      rxclk,
    input  logic                      clr,
    srsystem_frame_counter_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  len_q, len_d;
    logic [CW-1:0]  bit_idx_q, bit_idx_d;
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic           rxf_q, rxf_d;
    logic           overrun_q, overrun_d;
    logic           len_err_q, len_err_d;
    logic           len_ok;

    assign len_ok = (bus.frame_len != '0) && (bus.frame_len <= CW'(MAX_BITS));

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        bit_idx_d   = bit_idx_q;
        frame_cnt_d = frame_cnt_q;
        rxf_d       = rxf_q;
        overrun_d   = overrun_q;
        len_err_d   = len_err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (len_ok) begin
                        len_d     = bus.frame_len;
                        bit_idx_d = '0;
                        rxf_d     = 1'b0;
                        state_d   = S_COUNT;
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
            end
            S_COUNT: begin
                if (bus.abort) begin
                    bit_idx_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    // A start mid-frame is only recorded; the current frame keeps counting.
                    if (bus.start) begin
                        overrun_d = 1'b1;
                    end
                    if (bus.bit_en) begin
                        if (bit_idx_q == len_q - CW'(1)) begin
                            bit_idx_d   = len_q;
                            rxf_d       = 1'b1;
                            frame_cnt_d = frame_cnt_q + FCW'(1);
                            state_d     = S_DONE;
                        end else begin
                            bit_idx_d = bit_idx_q + CW'(1);
                        end
                    end
                end
            end
            S_DONE: begin
                if (bus.abort) begin
                    rxf_d     = 1'b0;
                    bit_idx_d = '0;
                    state_d   = S_IDLE;
                end else if (bus.start && len_ok) begin
                    len_d     = bus.frame_len;
                    bit_idx_d = '0;
                    rxf_d     = 1'b0;
                    state_d   = S_COUNT;
                end else begin
                    if (bus.start) begin
                        len_err_d = 1'b1;
                    end
                    // Pulse mode leaves DONE after one cycle regardless of other inputs.
                    if (!HOLD_MODE) begin
                        rxf_d     = 1'b0;
                        bit_idx_d = '0;
                        state_d   = S_IDLE;
                    end
                end
            end
            default: begin
                rxf_d     = 1'b0;
                bit_idx_d = '0;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge rxclk) begin
        if (!clr) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            bit_idx_q   <= '0;
            frame_cnt_q <= '0;
            rxf_q       <= 1'b0;
            overrun_q   <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            bit_idx_q   <= bit_idx_d;
            frame_cnt_q <= frame_cnt_d;
            rxf_q       <= rxf_d;
            overrun_q   <= overrun_d;
            len_err_q   <= len_err_d;
        end
    end

    assign bus.RXF       = rxf_q;
    assign bus.busy      = (state_q == S_COUNT);
    assign bus.bit_idx   = bit_idx_q;
    assign bus.frame_cnt = frame_cnt_q;
    assign bus.overrun   = overrun_q;
    assign bus.len_err   = len_err_q;
endmodule

// File: tb/tb_srsystem_frame_counter.sv
// tb/tb_srsystem_frame_counter.sv - randomized and directed bench for srsystem_frame_counter (hold and pulse variants)
module tb_srsystem_frame_counter;
    logic       rxclk = 1'b0;
    logic       clr = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       bit_en = 1'b0;
    logic [3:0] frame_len = 4'd0;
    bit         chk_en = 1'b0;
    int         checks = 0;
    int         errors = 0;

    always #5 rxclk = ~rxclk;

    srsystem_frame_counter_if #(.CW(4), .FCW(8)) ifh ();
    srsystem_frame_counter_if #(.CW(4), .FCW(2)) ifp ();

    assign ifh.start = start;
    assign ifh.abort = abort;
    assign ifh.bit_en = bit_en;
    assign ifh.frame_len = frame_len;
    assign ifp.start = start;
    assign ifp.abort = abort;
    assign ifp.bit_en = bit_en;
    assign ifp.frame_len = frame_len;

    srsystem_frame_counter #(.MAX_BITS(11), .CW(4), .FCW(8), .HOLD_MODE(1'b1)) dut_h (
        .rxclk(rxclk), .clr(clr), .bus(ifh.slave)
    );
    srsystem_frame_counter #(.MAX_BITS(11), .CW(4), .FCW(2), .HOLD_MODE(1'b0)) dut_p (
        .rxclk(rxclk), .clr(clr), .bus(ifp.slave)
    );

    // Frame-level view: in_frame while counting, rxf marks a received frame awaiting release.
    typedef struct {
        bit in_frame;
        bit rxf;
        int len;
        int idx;
        int cnt;
        bit ovr;
        bit lerr;
    } mdl_t;

    mdl_t mh = '{0, 0, 0, 0, 0, 0, 0};
    mdl_t mp = '{0, 0, 0, 0, 0, 0, 0};

    function automatic mdl_t step(mdl_t m, bit hold, int fcw, bit rst, bit st, bit ab, bit be, int fl);
        mdl_t n = m;
        bit legal = (fl >= 1) && (fl <= 11);
        if (!rst) begin
            n = '{0, 0, 0, 0, 0, 0, 0};
            return n;
        end
        if (m.in_frame) begin
            if (ab) begin
                n.in_frame = 0;
                n.idx = 0;
            end else begin
                if (st) n.ovr = 1;
                if (be) begin
                    n.idx = m.idx + 1;
                    if (n.idx == m.len) begin
                        n.in_frame = 0;
                        n.rxf = 1;
                        n.cnt = (m.cnt + 1) % (1 << fcw);
                    end
                end
            end
        end else if (m.rxf && ab) begin
            n.rxf = 0;
            n.idx = 0;
        end else if (st && legal) begin
            n.in_frame = 1;
            n.len = fl;
            n.idx = 0;
            n.rxf = 0;
        end else begin
            if (st) n.lerr = 1;
            if (m.rxf && !hold) begin
                n.rxf = 0;
                n.idx = 0;
            end
        end
        return n;
    endfunction

    always @(posedge rxclk) begin
        mh = step(mh, 1'b1, 8, clr, start, abort, bit_en, int'(frame_len));
        mp = step(mp, 1'b0, 2, clr, start, abort, bit_en, int'(frame_len));
    end

    always @(negedge rxclk) begin
        if (chk_en) begin
            logic [15:0] eh, ah;
            logic [9:0]  ep, ap;
            eh = {mh.rxf, mh.in_frame, 4'(mh.idx), 8'(mh.cnt), mh.ovr, mh.lerr};
            ah = {ifh.RXF, ifh.busy, ifh.bit_idx, ifh.frame_cnt, ifh.overrun, ifh.len_err};
            ep = {mp.rxf, mp.in_frame, 4'(mp.idx), 2'(mp.cnt), mp.ovr, mp.lerr};
            ap = {ifp.RXF, ifp.busy, ifp.bit_idx, ifp.frame_cnt, ifp.overrun, ifp.len_err};
            checks++;
            if (ah !== eh) begin
                errors++;
                $display("FAIL model_hold t=%0t actual %h required %h", $time, ah, eh);
            end
            checks++;
            if (ap !== ep) begin
                errors++;
                $display("FAIL model_pulse t=%0t actual %h required %h", $time, ap, ep);
            end
        end
    end

    task automatic tick();
        @(posedge rxclk);
        #1;
    endtask

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic do_reset(int n);
        clr = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        bit_en = 1'b0;
        repeat (n) tick();
        clr = 1'b1;
    endtask

    task automatic do_start(int len);
        start = 1'b1;
        frame_len = 4'(len);
        tick();
        start = 1'b0;
    endtask

    task automatic strobe();
        bit_en = 1'b1;
        tick();
        bit_en = 1'b0;
    endtask

    int exp_wrap[5] = '{1, 2, 3, 0, 1};

    initial begin
        do_reset(2);
        chk_en = 1'b1;
        check("reset_outputs", int'({ifh.RXF, ifh.busy, ifh.bit_idx, ifh.frame_cnt, ifh.overrun, ifh.len_err}), 0);

        // mid-frame reset
        do_start(11);
        repeat (5) strobe();
        check("pre_reset_idx", int'(ifh.bit_idx), 5);
        do_reset(2);
        check("midreset_outputs", int'({ifh.RXF, ifh.busy, ifh.bit_idx, ifh.frame_cnt}), 0);
        tick();
        check("midreset_no_rxf", int'(ifh.RXF), 0);

        // nominal hold-mode frame of 11 bits, strobes 16 cycles apart
        do_start(11);
        check("nom_busy", int'(ifh.busy), 1);
        for (int i = 0; i < 11; i++) begin
            strobe();
            if (i < 10) repeat (15) tick();
        end
        check("nom_rxf", int'(ifh.RXF), 1);
        check("nom_idx", int'(ifh.bit_idx), 11);
        check("nom_cnt", int'(ifh.frame_cnt), 1);
        repeat (5) tick();
        check("nom_rxf_held", int'(ifh.RXF), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("nom_rxf_abort", int'(ifh.RXF), 0);

        // pulse mode back-to-back start
        do_reset(1);
        do_start(3);
        repeat (3) strobe();
        check("pulse_rxf", int'(ifp.RXF), 1);
        do_start(3);
        check("pulse_rxf_drop", int'(ifp.RXF), 0);
        check("pulse_busy", int'(ifp.busy), 1);
        check("pulse_cnt", int'(ifp.frame_cnt), 1);

        // illegal lengths and overrun
        do_reset(1);
        do_start(0);
        check("len0_err", int'(ifh.len_err), 1);
        check("len0_busy", int'(ifh.busy), 0);
        do_reset(1);
        do_start(12);
        check("len12_err", int'(ifh.len_err), 1);
        do_reset(1);
        do_start(11);
        repeat (4) strobe();
        do_start(11);
        check("ovr_flag", int'(ifh.overrun), 1);
        repeat (7) strobe();
        check("ovr_rxf", int'(ifh.RXF), 1);
        check("ovr_idx", int'(ifh.bit_idx), 11);

        // abort wins over start and bit_en at the final bit
        do_reset(1);
        do_start(11);
        repeat (10) strobe();
        abort = 1'b1;
        start = 1'b1;
        bit_en = 1'b1;
        frame_len = 4'd5;
        tick();
        abort = 1'b0;
        start = 1'b0;
        bit_en = 1'b0;
        check("prio_busy", int'(ifh.busy), 0);
        check("prio_rxf", int'(ifh.RXF), 0);
        check("prio_cnt", int'(ifh.frame_cnt), 0);
        check("prio_idx", int'(ifh.bit_idx), 0);

        // frame counter wrap with FCW=2
        do_reset(1);
        for (int i = 0; i < 5; i++) begin
            do_start(1);
            strobe();
            check("wrap_cnt", int'(ifp.frame_cnt), exp_wrap[i]);
            tick();
        end

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            clr = ($urandom_range(0, 199) != 0);
            start = ($urandom_range(0, 9) == 0);
            abort = ($urandom_range(0, 24) == 0);
            bit_en = ($urandom_range(0, 2) == 0);
            frame_len = 4'($urandom_range(0, 13));
            tick();
        end
        clr = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        bit_en = 1'b0;
        repeat (3) tick();
        @(negedge rxclk);
        chk_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
